// File: rtl/pipelined_group_cla.sv
// Two-stage carry-lookahead adder. Group generate/propagate are registered in
// stage 1, and stage 2 resolves the group carries and registers the sum.
module pipelined_group_cla #(
    parameter int WIDTH       = 16,
    parameter int GROUP       = 4,
    parameter int APPROX_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     cin,
    input  logic                     approx_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         sum,
    output logic                     cout,
    output logic [WIDTH/GROUP-1:0]   gg,
    output logic [WIDTH/GROUP-1:0]   gp
);

    localparam int NG  = WIDTH / GROUP;
    localparam int AB  = (APPROX_BITS > 0) ? APPROX_BITS - 1 : 0;
    localparam bit APX = (APPROX_BITS > 0);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             fix;
        logic [NG-1:0]    cg;
        logic [NG-1:0]    cp;
        logic [NG-1:0]    gg;
        logic [NG-1:0]    gp;
    } s1_t;

    s1_t              s1_d;
    s1_t              s1_q;
    logic             s1_valid;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic [WIDTH-1:0] s2_sum;
    logic             s2_cout;

    function automatic logic [2*NG-1:0] group_gp(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [NG-1:0] g;
        logic [NG-1:0] p;
        logic          c;
        g = '0;
        p = '0;
        for (int k = 0; k < NG; k++) begin
            c    = 1'b0;
            p[k] = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                c    = (x[k*GROUP+i] & y[k*GROUP+i])
                     | ((x[k*GROUP+i] ^ y[k*GROUP+i]) & c);
                p[k] = p[k] & (x[k*GROUP+i] ^ y[k*GROUP+i]);
            end
            g[k] = c;
        end
        return {g, p};
    endfunction

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // Approximate mode folds the low part into operands with no internal
    // carries; only the top approximate bit keeps a&b so its carry survives.
    always_comb begin
        ea       = a;
        eb       = b;
        s1_d     = '0;
        s1_d.cin = cin;
        if (APX && approx_en) begin
            for (int i = 0; i < AB; i++) begin
                ea[i] = a[i] | b[i];
                eb[i] = 1'b0;
            end
            s1_d.cin = 1'b0;
            s1_d.fix = a[AB] & b[AB];
        end
        s1_d.a              = ea;
        s1_d.b              = eb;
        {s1_d.gg, s1_d.gp}  = group_gp(a, b);
        {s1_d.cg, s1_d.cp}  = group_gp(ea, eb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) s1_q <= s1_d;
        end
    end

    always_comb begin
        logic c;
        logic ci;
        logic p;
        s2_sum = '0;
        c      = s1_q.cin;
        for (int k = 0; k < NG; k++) begin
            ci = c;
            for (int i = 0; i < GROUP; i++) begin
                p                  = s1_q.a[k*GROUP+i] ^ s1_q.b[k*GROUP+i];
                s2_sum[k*GROUP+i]  = p ^ ci;
                ci = (s1_q.a[k*GROUP+i] & s1_q.b[k*GROUP+i]) | (p & ci);
            end
            c = s1_q.cg[k] | (s1_q.cp[k] & c);
        end
        s2_sum[AB] = s2_sum[AB] | s1_q.fix;
        s2_cout    = c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            gg       <= '0;
            gp       <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= s2_sum;
                cout <= s2_cout;
                gg   <= s1_q.gg;
                gp   <= s1_q.gp;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_group_cla.sv
// Randomized bench for pipelined_group_cla against an arithmetic model,
// plus a wide sweep on a WIDTH=8 GROUP=2 exact-only instance.
module tb_pipelined_group_cla;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, cin, approx_en;
    logic        out_valid, out_ready, cout;
    logic [15:0] a, b, sum;
    logic [3:0]  gg, gp;

    logic        v8, rdy8, cin8, apx8, ov8, or8, co8;
    logic [7:0]  a8, b8, s8;
    logic [3:0]  gg8, gp8;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;
    int pidx     = 0;

    longint unsigned q[$];
    longint unsigned q8[$];
    logic            stall_prev = 1'b0;
    logic [25:0]     held;

    always #5 clk = ~clk;

    pipelined_group_cla #(.WIDTH(16), .GROUP(4), .APPROX_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .approx_en(approx_en),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .gg(gg), .gp(gp)
    );

    pipelined_group_cla #(.WIDTH(8), .GROUP(2), .APPROX_BITS(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
        .a(a8), .b(b8), .cin(cin8), .approx_en(apx8),
        .out_valid(ov8), .out_ready(or8), .sum(s8),
        .cout(co8), .gg(gg8), .gp(gp8)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Packed {cout, sum, gg, gp} straight from the arithmetic definition.
    function automatic longint unsigned model(
        int w, int g, int ab,
        longint unsigned x, longint unsigned y, bit c, bit ap
    );
        longint unsigned s, hi, lo, mg, xs, ys, rg, rp;
        int ng;
        ng = w / g;
        if (ap && ab > 0) begin
            hi = (x >> ab) + (y >> ab) + ((x >> (ab-1)) & (y >> (ab-1)) & 1);
            lo = (x | y) & ((64'd1 << ab) - 1);
            s  = (hi << ab) | lo;
        end else begin
            s = x + y + c;
        end
        s  = s & ((64'd1 << (w+1)) - 1);
        mg = (64'd1 << g) - 1;
        rg = 0;
        rp = 0;
        for (int k = 0; k < ng; k++) begin
            xs = (x >> (k*g)) & mg;
            ys = (y >> (k*g)) & mg;
            rg = rg | ((((xs + ys) >> g) & 1) << k);
            if (((xs ^ ys) & mg) == mg) rp = rp | (64'd1 << k);
        end
        return (s << (2*ng)) | (rg << ng) | rp;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("hold", {out_valid, cout, sum, gg, gp}, held);
            check("in_ready", in_ready, !(q.size() == 2 && !out_ready));
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("spurious", 1, 0);
                else check("data", {cout, sum, gg, gp}, q.pop_front());
            end
            if (in_valid && in_ready)
                q.push_back(model(16, 4, 4, a, b, cin, approx_en));
            stall_prev = out_valid && !out_ready;
            held       = {out_valid, cout, sum, gg, gp};

            check("rdy8", rdy8, !(q8.size() == 2 && !or8));
            if (ov8 && or8) begin
                if (q8.size() == 0) check("spurious8", 1, 0);
                else check("data8", {co8, s8, gg8, gp8}, q8.pop_front());
            end
            if (v8 && rdy8)
                q8.push_back(model(8, 2, 0, a8, b8, cin8, apx8));
        end
    end

    always @(posedge clk) begin
        #1;
        if (mode == 1) begin
            out_ready = (pidx % 4 == 0) || (pidx % 4 == 3);
            pidx++;
        end else if (mode == 2) begin
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic drive(input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic ap);
        int n;
        a         = x;
        b         = y;
        cin       = c;
        approx_en = ap;
        in_valid  = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (n == 50) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic lat_beat(input logic [15:0] x, input logic [15:0] y,
                            input logic c, input logic ap);
        drive(x, y, c, ap);
        check("lat1", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat2", out_valid, 1);
    endtask

    task automatic drain();
        int n;
        mode      = 0;
        out_ready = 1'b1;
        for (n = 0; n < 200 && (q.size() > 0 || q8.size() > 0); n++)
            @(posedge clk);
        #1;
        check("drain", q.size() + q8.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        {in_valid, a, b, cin, approx_en} = '0;
        out_ready = 1'b1;
        {v8, a8, b8, cin8, apx8} = '0;
        or8 = 1'b1;
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_outs", {cout, sum, gg, gp}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        lat_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check("carry_chain", {cout, sum, gg, gp},
              {1'b1, 16'h0000, 4'b0001, 4'b1110});
        @(posedge clk);
        #1;
        lat_beat(16'h00F8, 16'h0018, 1'b1, 1'b1);
        check("approx", {cout, sum}, {1'b0, 16'h0118});
        drain();

        mode = 1;
        pidx = 0;
        for (int i = 0; i < 8; i++)
            drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        drain();

        mode = 2;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        drain();

        out_ready = 1'b0;
        drive(16'h1234, 16'h4321, 1'b0, 1'b0);
        drive(16'hABCD, 16'h1111, 1'b1, 1'b0);
        check("full_ready", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_ready", in_ready, 1);
        check("rst_mid_outs", {cout, sum, gg, gp}, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("no_stale", out_valid, 0);
        end
        lat_beat(16'h8000, 16'h8000, 1'b1, 1'b0);
        drain();

        for (int ai = 0; ai < 256; ai++) begin
            for (int j = 0; j < 32; j++) begin
                a8   = 8'(ai);
                b8   = (j == 0) ? 8'h00 : (j == 1) ? 8'hFF : 8'($urandom);
                cin8 = 1'($urandom);
                apx8 = 1'($urandom);
                v8   = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        v8 = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
